vending_machine_multi: RTL and testbench
========================================

// Module: vending_machine_multi
// PURPOSE
//   Parametrised successor to the single-product coin vending FSM. Multi-item
//   machine: accumulates credit from 5/10/20 Rs coins, vends a selected item at
//   a per-item price, refunds on cancel. Change is returned greedily, one coin
//   per cycle. Sits between the coin acceptor front-end and the dispenser driver.
// PARAMETERS
//   NUM_ITEMS    4                   number of selectable items
//   CREDIT_W     8                   credit register width, in 5 Rs units
//   PRICE_LIST   {8'd5,8'd4,8'd2,8'd3}  packed NUM_ITEMS*CREDIT_W prices in units; item0 = LSB slice (15 Rs)
//   MAX_CREDIT   20                  credit ceiling in units (100 Rs)
//   TIMEOUT_CYC  1000                idle cycles before auto-refund (VM_TIMEOUT_EN only)
// PORTS
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   in           in   2         coin: 00 none, 01 5 Rs, 10 10 Rs, 11 20 Rs
//   sel_valid    in   1         item-select strobe
//   sel          in   SEL_W     item index, SEL_W = $clog2(NUM_ITEMS)
//   cancel       in   1         refund request
//   out          out  1         one-cycle vend pulse
//   item         out  SEL_W     index of vended item, valid with out
//   change       out  2         returned coin this cycle, same encoding as in
//   coin_reject  out  1         one-cycle pulse: coin not accepted, return to user
//   busy         out  1         high in VEND and CHANGE states
//   credit       out  CREDIT_W  current credit in units
// BEHAVIOUR
//   - Reset: state IDLE; out, item, change, coin_reject, busy, credit all 0.
//     Reset mid-VEND/CHANGE aborts immediately; pending change is discarded.
//   - States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
//   - Coin sampled each edge in IDLE/CREDIT; credit updated at that same edge
//     (visible the next cycle). If credit+coin > MAX_CREDIT: coin_reject, credit held.
//   - sel_valid sampled in IDLE/CREDIT: if credit >= PRICE_LIST[sel] -> VEND;
//     otherwise ignored, credit retained, no pulse. sel >= NUM_ITEMS is ignored.
//   - VEND (1 cycle): out=1, item=sel latched, credit -= price;
//     next = CHANGE if remainder > 0, else IDLE.
//   - cancel in IDLE/CREDIT with credit>0 -> CHANGE with full credit.
//   - CHANGE: one coin per cycle, greedy: 11 if credit>=4, else 10 if >=2, else 01;
//     credit decrements to match; credit=0 -> IDLE (change=00 that cycle).
//   - Simultaneous: cancel beats sel_valid. A coin in the same cycle as sel_valid
//     or cancel is rejected (coin_reject); decision uses pre-coin credit.
//   - Coins arriving while busy are rejected; sel_valid/cancel while busy are ignored.
// CONFIGURATION
//   VM_TIMEOUT_EN defined: idle counter runs in CREDIT and clears on any coin,
//     sel_valid or cancel; reaching TIMEOUT_CYC forces CHANGE (full refund).
//   VM_TIMEOUT_EN undefined: no counter; credit is held indefinitely.
// STRUCTURE
//   vending_pkg: coin codes (COIN_NONE/5/10/20), unit values, state encoding.
//   Sub-module vm_change_dispenser: greedy coin selection from a credit value;
//   outputs the coin code and its unit value; purely combinational, driven by
//   the FSM credit register.
// TESTING
//   1 reset; coins 10,10 (credit 4); sel=0 -> out 1 cycle, item=0, change 01 once, credit 0.
//   2 coin 01, sel=3 -> no out, credit 1; coin 11 -> credit 5; sel=3 -> out, no change.
//   3 coins 11,10,01 (credit 7), cancel -> change 11,10,01 on 3 consecutive cycles, busy high.
//   4 five coins 11 -> credit 20; coin 01 -> coin_reject, credit stays 20.
//   5 coin 10 together with sel_valid, sel=1, credit 0 -> coin_reject, no out;
//     reset during CHANGE -> change 00, credit 0 immediately.
//   6 VM_TIMEOUT_EN, TIMEOUT_CYC=16: coin 10, idle 16 cycles -> change 10, back to IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
//   Shared definitions for the multi-item vending machine:
//   - coin codes as seen on the coin-acceptor and change buses
//   - value of each coin in 5 Rs credit units
//   - FSM state encoding (plain localparams, legacy-compatible)
//   - coin_units(): maps a coin code to its unit value
// ---------------------------------------------------------------------------
package vending_pkg;

  typedef logic [1:0] coin_t;

  // Coin codes, shared by the acceptor input and the change output.
  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_5    = 2'b01;
  localparam coin_t COIN_10   = 2'b10;
  localparam coin_t COIN_20   = 2'b11;

  // Coin values in 5 Rs units.
  localparam int UNIT_5  = 1;
  localparam int UNIT_10 = 2;
  localparam int UNIT_20 = 4;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;  // no credit
  localparam logic [1:0] ST_CREDIT = 2'd1;  // credit > 0, accepting coins
  localparam logic [1:0] ST_VEND   = 2'd2;  // one-cycle dispense pulse
  localparam logic [1:0] ST_CHANGE = 2'd3;  // returning coins one per cycle

  // Unit value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [2:0] coin_units(input coin_t coin);
    logic [2:0] units;
    case (coin)
      COIN_5:  units = 3'(UNIT_5);
      COIN_10: units = 3'(UNIT_10);
      COIN_20: units = 3'(UNIT_20);
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vending_machine_multi_if
//   Bundles the coin-acceptor / item-select front-end signals and the
//   dispenser-driver outputs of vending_machine_multi.
//   master : front-end side (drives coin, select, cancel; observes results)
//   slave  : vending machine side
//   Signals:
//     in          coin code 00 none, 01 5 Rs, 10 10 Rs, 11 20 Rs
//     sel_valid   item-select strobe
//     sel         item index
//     cancel      refund request
//     out         one-cycle vend pulse
//     item        index of the vended item, valid with out
//     change      returned coin this cycle (coin encoding)
//     coin_reject one-cycle pulse, coin not accepted
//     busy        machine is vending or returning change
//     credit      current credit in 5 Rs units
// ---------------------------------------------------------------------------
interface vending_machine_multi_if #(
  parameter int SEL_W    = 2,
  parameter int CREDIT_W = 8
);

  logic [1:0]          in;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic                out;
  logic [SEL_W-1:0]    item;
  logic [1:0]          change;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output in, sel_valid, sel, cancel,
    input  out, item, change, coin_reject, busy, credit
  );

  modport slave (
    input  in, sel_valid, sel, cancel,
    output out, item, change, coin_reject, busy, credit
  );

endinterface

// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
//   Greedy change selection: picks the largest coin not exceeding the given
//   credit. Purely combinational; fed from the FSM credit register.
//   Ports:
//     i_credit  remaining credit in 5 Rs units
//     o_coin    coin code to return (COIN_NONE when credit is zero)
//     o_units   value of o_coin in units
// ---------------------------------------------------------------------------
module vm_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [CREDIT_W-1:0] o_units
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latch).
    o_coin  = COIN_NONE;
    o_units = '0;
    if (i_credit >= CREDIT_W'(UNIT_20)) begin
      o_coin  = COIN_20;
      o_units = CREDIT_W'(UNIT_20);
    end else if (i_credit >= CREDIT_W'(UNIT_10)) begin
      o_coin  = COIN_10;
      o_units = CREDIT_W'(UNIT_10);
    end else if (i_credit != '0) begin
      o_coin  = COIN_5;
      o_units = CREDIT_W'(UNIT_5);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//   Multi-item coin vending FSM. Accumulates credit from 5/10/20 Rs coins,
//   vends a selected item at its per-item price and returns change greedily,
//   one coin per cycle. Cancel refunds the full credit.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-low reset
//     bus   vending_machine_multi_if.slave (coin/select/cancel in,
//           out/item/change/coin_reject/busy/credit out)
//   Parameters:
//     NUM_ITEMS, CREDIT_W, PRICE_LIST (item0 in the LSB slice, in units),
//     MAX_CREDIT (credit ceiling in units), TIMEOUT_CYC.
//   Optional feature (macro VM_TIMEOUT_EN): an idle counter runs while
//   credit is held; after TIMEOUT_CYC idle cycles the credit is refunded.
//   Without the macro the credit is held indefinitely.
// ---------------------------------------------------------------------------
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                            NUM_ITEMS   = 4,
  parameter int                            CREDIT_W    = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST  = {8'd5, 8'd4, 8'd2, 8'd3},
  parameter int                            MAX_CREDIT  = 20,
  parameter int                            TIMEOUT_CYC = 1000,
  localparam int                           SEL_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input logic                   clk,
  input logic                   rst,
  vending_machine_multi_if.slave bus
);

  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [SEL_W-1:0]    r_item;
  logic                r_coin_reject;

  logic [1:0]          w_disp_coin;
  logic [CREDIT_W-1:0] w_disp_units;
  logic [CREDIT_W-1:0] w_price;
  logic                w_sel_in_range;
  logic [CREDIT_W:0]   w_credit_sum;
  logic                w_over;
  logic                w_coin_present;
  logic                w_can_vend;
  logic                w_timeout;

  vm_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_dispenser (
    .i_credit (r_credit),
    .o_coin   (w_disp_coin),
    .o_units  (w_disp_units)
  );

  // Price of the selected item; out-of-range selections never match.
  always_comb begin
    w_price        = '0;
    w_sel_in_range = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        w_price        = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        w_sel_in_range = 1'b1;
      end
    end
  end

  // One extra bit so the ceiling test cannot wrap.
  assign w_credit_sum   = {1'b0, r_credit} + (CREDIT_W+1)'(coin_units(bus.in));
  assign w_over         = w_credit_sum > (CREDIT_W+1)'(MAX_CREDIT);
  assign w_coin_present = bus.in != COIN_NONE;
  assign w_can_vend     = w_sel_in_range && (r_credit >= w_price);

`ifdef VM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_idle_cnt;
  logic            w_idle;

  // Any coin, select or cancel counts as activity, even if it is refused.
  assign w_idle    = (r_state == ST_CREDIT) && !w_coin_present &&
                     !bus.sel_valid && !bus.cancel;
  assign w_timeout = w_idle && (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
    end else if (!w_idle || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments for all state; blocking here would
      // let the update order inside this block change behaviour.
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_item        <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      case (r_state)
        ST_IDLE, ST_CREDIT: begin
          // A coin arriving with a command is refused; the command is
          // judged on the credit held before that coin.
          if (w_coin_present && (bus.sel_valid || bus.cancel || w_over)) begin
            r_coin_reject <= 1'b1;
          end
          if (bus.cancel) begin
            if (r_credit != '0) begin
              r_state <= ST_CHANGE;
            end
          end else if (bus.sel_valid) begin
            if (w_can_vend) begin
              r_state  <= ST_VEND;
              r_item   <= bus.sel;
              r_credit <= r_credit - w_price;
            end
          end else if (w_coin_present) begin
            if (!w_over) begin
              r_credit <= w_credit_sum[CREDIT_W-1:0];
              r_state  <= ST_CREDIT;
            end
          end else if (w_timeout) begin
            r_state <= ST_CHANGE;
          end
        end

        ST_VEND: begin
          r_coin_reject <= w_coin_present;
          // r_credit already holds the remainder after the price.
          r_state       <= (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end

        ST_CHANGE: begin
          r_coin_reject <= w_coin_present;
          if (r_credit == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_credit <= r_credit - w_disp_units;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out         = (r_state == ST_VEND);
  assign bus.item        = r_item;
  assign bus.change      = (r_state == ST_CHANGE) ? w_disp_coin : COIN_NONE;
  assign bus.coin_reject = r_coin_reject;
  assign bus.busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);
  assign bus.credit      = r_credit;

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
//   Self-checking bench for vending_machine_multi. A transaction-level model
//   (credit as an integer, change as a queue of coin values) predicts every
//   output each cycle; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

  localparam int NUM_ITEMS   = 4;
  localparam int CREDIT_W    = 8;
  localparam int SEL_W       = 2;
  localparam int MAX_CREDIT  = 20;
  localparam int TIMEOUT_CYC = 1000;
  localparam int PRICE [NUM_ITEMS] = '{3, 2, 4, 5};

  logic clk;
  logic rst;

  vending_machine_multi_if #(.SEL_W(SEL_W), .CREDIT_W(CREDIT_W)) vif ();

  vending_machine_multi dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_credit;
  bit  m_vend;
  bit  m_refund;
  bit  m_rej;
  int  m_item;
  int  m_q[$];
  int  m_idle;

  function automatic int units_of(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int code_of(input int u);
    case (u)
      4:       return 3;
      2:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_vend = 0; m_refund = 0; m_rej = 0; m_item = 0; m_idle = 0;
    m_q.delete();
  endtask

  // Full refund of the current credit, largest coins first.
  task automatic start_refund();
    int rem;
    m_refund = 1;
    m_q.delete();
    rem = m_credit;
    while (rem > 0) begin
      if (rem >= 4)      begin m_q.push_back(4); rem -= 4; end
      else if (rem >= 2) begin m_q.push_back(2); rem -= 2; end
      else               begin m_q.push_back(1); rem -= 1; end
    end
  endtask

  task automatic model_step(input logic [1:0] c, input bit sv, input logic [1:0] s, input bit cn);
    bit busy;
    int v;
    busy  = m_vend || m_refund;
    v     = units_of(c);
    m_rej = (v != 0) && (busy || sv || cn || (m_credit + v > MAX_CREDIT));
    if (m_vend) begin
      m_vend = 0;
      if (m_credit > 0) start_refund();
    end else if (m_refund) begin
      if (m_q.size() > 0) m_credit -= m_q.pop_front();
      else m_refund = 0;
    end else begin
      if (cn) begin
        if (m_credit > 0) start_refund();
      end else if (sv) begin
        if (int'(s) < NUM_ITEMS && m_credit >= PRICE[s]) begin
          m_vend = 1; m_item = int'(s); m_credit -= PRICE[s];
        end
      end else if (v != 0) begin
        if (m_credit + v <= MAX_CREDIT) m_credit += v;
      end
`ifdef VM_TIMEOUT_EN
      if (!cn && !sv && v == 0 && m_credit > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_idle = 0;
          start_refund();
        end
      end else begin
        m_idle = 0;
      end
`endif
    end
  endtask

  task automatic compare_all();
    check("out",         vif.out,         m_vend);
    check("item",        vif.item,        m_item);
    check("change",      vif.change,      (m_refund && m_q.size() > 0) ? code_of(m_q[0]) : 0);
    check("coin_reject", vif.coin_reject, m_rej);
    check("busy",        vif.busy,        m_vend || m_refund);
    check("credit",      vif.credit,      m_credit);
  endtask

  // Apply inputs just after an edge, clock once, compare just after the edge.
  task automatic cycle(input logic [1:0] c, input bit sv, input logic [1:0] s, input bit cn);
    vif.in = c; vif.sel_valid = sv; vif.sel = s; vif.cancel = cn;
    model_step(c, sv, s, cn);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 0, 2'd0, 0);
  endtask

  logic [1:0] rc;
  logic [1:0] rs;
  bit         rsv;
  bit         rcn;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    vif.in = 2'b00; vif.sel_valid = 1'b0; vif.sel = '0; vif.cancel = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_out",    vif.out,         0);
    check("rst_item",   vif.item,        0);
    check("rst_change", vif.change,      0);
    check("rst_reject", vif.coin_reject, 0);
    check("rst_busy",   vif.busy,        0);
    check("rst_credit", vif.credit,      0);
    rst = 1'b1;

    // 1: 10+10 -> credit 4, buy item0 (price 3) -> one 5 Rs coin back.
    cycle(2'b10, 0, 2'd0, 0);
    cycle(2'b10, 0, 2'd0, 0);
    check("t1_credit4", vif.credit, 4);
    cycle(2'b00, 1, 2'd0, 0);
    check("t1_out", vif.out, 1);
    check("t1_item", vif.item, 0);
    idle(1);
    check("t1_change01", vif.change, 1);
    idle(1);
    check("t1_credit0", vif.credit, 0);
    idle(1);
    check("t1_idle_busy", vif.busy, 0);

    // 2: credit 1, item3 (price 5) refused; add 20 Rs, exact-price vend.
    cycle(2'b01, 0, 2'd0, 0);
    cycle(2'b00, 1, 2'd3, 0);
    check("t2_no_out", vif.out, 0);
    check("t2_credit1", vif.credit, 1);
    cycle(2'b11, 0, 2'd0, 0);
    check("t2_credit5", vif.credit, 5);
    cycle(2'b00, 1, 2'd3, 0);
    check("t2_out", vif.out, 1);
    check("t2_item3", vif.item, 3);
    idle(1);
    check("t2_no_change", vif.change, 0);

    // 3: credit 7, cancel -> 20,10,5 Rs on consecutive cycles.
    cycle(2'b11, 0, 2'd0, 0);
    cycle(2'b10, 0, 2'd0, 0);
    cycle(2'b01, 0, 2'd0, 0);
    cycle(2'b00, 0, 2'd0, 1);
    check("t3_chg20", vif.change, 3);
    check("t3_busy", vif.busy, 1);
    idle(1);
    check("t3_chg10", vif.change, 2);
    idle(1);
    check("t3_chg5", vif.change, 1);
    idle(2);

    // 4: fill to the ceiling, next coin is refused.
    for (int i = 0; i < 5; i++) cycle(2'b11, 0, 2'd0, 0);
    check("t4_credit20", vif.credit, 20);
    cycle(2'b01, 0, 2'd0, 0);
    check("t4_reject", vif.coin_reject, 1);
    check("t4_held20", vif.credit, 20);
    cycle(2'b00, 0, 2'd0, 1);
    idle(8);

    // 5: coin together with select at zero credit; then reset mid-refund.
    cycle(2'b10, 1, 2'd1, 0);
    check("t5_reject", vif.coin_reject, 1);
    check("t5_no_out", vif.out, 0);
    cycle(2'b11, 0, 2'd0, 0);
    cycle(2'b00, 0, 2'd0, 1);
    rst = 1'b0;
    #1;
    check("t5_rst_change", vif.change, 0);
    check("t5_rst_credit", vif.credit, 0);
    check("t5_rst_busy", vif.busy, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Credit left alone for a long time.
    cycle(2'b10, 0, 2'd0, 0);
    idle(TIMEOUT_CYC + 20);
`ifndef VM_TIMEOUT_EN
    check("hold_credit", vif.credit, 2);
`endif
    cycle(2'b00, 0, 2'd0, 1);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rc  = ($urandom_range(0, 99) < 45) ? 2'($urandom_range(1, 3)) : 2'b00;
      rsv = ($urandom_range(0, 99) < 20);
      rs  = 2'($urandom_range(0, 3));
      rcn = ($urandom_range(0, 99) < 5);
      cycle(rc, rsv, rs, rcn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
